// File: rtl/onehot_pkg.sv
// Shared types and constants for the multi-cycle one-hot position encoder.
// Early-exit behaviour is selected in the top by ONEHOT_EARLY_EXIT_EN.
package onehot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_PRIO   = 1'b1;

    // Ones-count only needs to distinguish none / one / many.
    localparam int unsigned     CNT_W     = 2;
    localparam logic [CNT_W-1:0] CNT_NONE  = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
    localparam logic [CNT_W-1:0] CNT_MULTI = 2'd2;

    function automatic logic [CNT_W-1:0] cnt_sat_add(input logic [CNT_W-1:0] a,
                                                     input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, CNT_MULTI}) ? CNT_MULTI : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/onehot_chunk_scan.sv
// Combinational scan of one chunk: any-bit flag, highest set local index,
// and ones-count saturated at two.
module onehot_chunk_scan
    import onehot_pkg::*;
#(
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned IDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] data,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c,
    output logic [CNT_W-1:0] cnt_c
);

    // Ascending walk so the last hit is the highest index.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        cnt_c   = CNT_NONE;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (data[i]) begin
                found_c = 1'b1;
                idx_c   = IDX_W'(i);
                cnt_c   = cnt_sat_add(cnt_c, CNT_ONE);
            end
        end
    end

endmodule

// File: rtl/onehot_pos_encoder.sv
// Multi-cycle one-hot to 1-based position encoder, MSB chunk first, with
// strict and MSB-priority modes. Define ONEHOT_EARLY_EXIT_EN to stop a strict
// scan as soon as a second set bit is seen.
module onehot_pos_encoder
    import onehot_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned POS_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic             out_multi
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IDX_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("onehot_pos_encoder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic [K_W-1:0]   k_q;
    logic             found_q;
    logic [POS_W-1:0] pos_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CHUNK-1:0] chunk_c;
    logic             c_found;
    logic [IDX_W-1:0] c_idx;
    logic [CNT_W-1:0] c_cnt;

    assign chunk_c = data_q[32'(k_q) * CHUNK +: CHUNK];

    onehot_chunk_scan #(
        .CHUNK (CHUNK)
    ) u_scan (
        .data    (chunk_c),
        .found_c (c_found),
        .idx_c   (c_idx),
        .cnt_c   (c_cnt)
    );

    // Running result including the chunk being examined this cycle.
    logic             scan_found_c;
    logic [POS_W-1:0] scan_pos_c;
    logic [CNT_W-1:0] scan_cnt_c;
    logic             early_c;
    logic             last_c;
    logic             res_multi_c;
    logic             res_zero_c;
    logic [POS_W-1:0] res_pos_c;

    always_comb begin
        scan_found_c = found_q | c_found;
        scan_cnt_c   = cnt_sat_add(cnt_q, c_cnt);
        scan_pos_c   = pos_q;
        if (!found_q && c_found) begin
            scan_pos_c = POS_W'(32'(k_q) * CHUNK + 32'(c_idx) + 32'd1);
        end
    end

`ifdef ONEHOT_EARLY_EXIT_EN
    assign early_c = (mode_q == MODE_STRICT) && (scan_cnt_c == CNT_MULTI);
`else
    assign early_c = 1'b0;
`endif

    assign last_c      = (k_q == '0) || early_c;
    assign res_multi_c = (scan_cnt_c == CNT_MULTI);
    assign res_zero_c  = (scan_cnt_c == CNT_NONE);
    assign res_pos_c   = (res_multi_c && mode_q == MODE_STRICT) ? '0 : scan_pos_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
            data_q    <= '0;
            mode_q    <= MODE_STRICT;
            k_q       <= '0;
            found_q   <= 1'b0;
            pos_q     <= '0;
            cnt_q     <= CNT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        mode_q   <= in_mode;
                        k_q      <= K_W'(NCHUNK - 1);
                        found_q  <= 1'b0;
                        pos_q    <= '0;
                        cnt_q    <= CNT_NONE;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    found_q <= scan_found_c;
                    pos_q   <= scan_pos_c;
                    cnt_q   <= scan_cnt_c;
                    k_q     <= k_q - K_W'(1);
                    if (last_c) begin
                        out_valid <= 1'b1;
                        out_pos   <= res_pos_c;
                        out_zero  <= res_zero_c;
                        out_multi <= res_multi_c;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/onehot_pos_encoder.md
Name: onehot_pos_encoder

Overview:
- Parametrised, multi-cycle successor to the combinational one-hot-to-position decoder in the RISC datapath.
- Scans a WIDTH-bit word CHUNK bits per cycle, MSB chunk first.
- Returns the 1-based position of the set bit, a zero flag and a multi-hot flag.
- Two modes: strict one-hot and MSB-priority. Valid/ready handshakes on both sides, so it can sit between the ALU/shift-amount logic and its consumer.

Parameters:
- WIDTH, 32: input word width; WIDTH % CHUNK == 0 required, elaboration error otherwise.
- CHUNK, 8: bits examined per scan cycle; NCHUNK = WIDTH/CHUNK.
- POS_W, $clog2(WIDTH+1): derived localparam; output position width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  word to encode.
- in_mode  in  1  0 = strict one-hot, 1 = MSB-priority.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_pos  out  POS_W  1-based bit position; 0 when none/invalid.
- out_zero  out  1  in_data was all zeros.
- out_multi  out  1  more than one bit set.

Behaviour:
- Reset (async, any state): FSM -> IDLE; out_valid=0, out_pos=0, out_zero=0, out_multi=0; in_ready=1 once rst deasserts; any in-flight request is dropped.
- FSM states IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_mode, set chunk index k=NCHUNK-1, clear found flag and ones-count, go to SCAN.
- SCAN: in_ready=0. Each cycle examine bits [k*CHUNK+CHUNK-1 : k*CHUNK].
  - First set bit seen (highest overall) records pos = bit index + 1.
  - Ones-count accumulates, saturating at 2.
  - After chunk 0 is scanned, go to DONE.
- Latency: accept on edge t -> out_valid high after edge t+NCHUNK (4 cycles at defaults).
- Result rules:
  - count 0: pos=0, zero=1, multi=0.
  - count 1: pos=index+1, zero=0, multi=0.
  - count 2, strict mode: pos=0, multi=1.
  - count 2, priority mode: pos=highest index+1, multi=1.
- DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready, go to IDLE and drop out_valid.
  - in_ready rises the cycle after the handshake; no overlap of input and output transfers.
- in_valid while not in IDLE is ignored; in_data changes after acceptance have no effect.
- WIDTH=32, CHUNK=32 degenerates to a single-cycle scan: latency 1.

Optional Feature:
- ONEHOT_EARLY_EXIT_EN defined: in strict mode, SCAN goes to DONE in the same cycle the ones-count reaches 2 (result pos=0, multi=1 already decided). Priority mode is unchanged.
- Macro undefined: always a full NCHUNK-cycle scan.

Decomposition:
- Package onehot_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - MODE_STRICT=1'b0, MODE_PRIO=1'b1;
  - ones-count width constant (2 bits, saturating).
- One combinational sub-module, onehot_chunk_scan (param CHUNK): outputs found, highest-set local index and ones-count saturated at 2 for one chunk.

Test Plan (WIDTH=32, CHUNK=8):
- Strict, in_data=0x8000_0000 -> out_pos=32, zero=0, multi=0; out_valid 4 cycles after accept.
- in_data=0x0000_0000 (either mode) -> out_pos=0, out_zero=1, out_multi=0.
- Strict, in_data=0x0300_0000 -> out_pos=0, multi=1. With ONEHOT_EARLY_EXIT_EN, out_valid 1 cycle after accept; otherwise 4 cycles.
- Priority, in_data=0x0000_0105 -> out_pos=9, multi=1, zero=0. Strict, same data -> out_pos=0, multi=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid/in_data -> outputs stable, in_ready=0, new request ignored. After out_ready, in_ready=1 the next cycle.
- Assert rst for 1 cycle in mid-SCAN (2nd chunk) -> out_valid stays 0, all outputs 0, in_ready=1 after deassert. A following request 0x0000_0001 returns pos=1.
